object_spawn_scheduler: RTL and testbench

Frame-paced spawn scheduler for a pool of `NUM_SLOTS` identical game-object slots, such as trees or pickups. The block sits between the level and game logic and the object instances. It keeps a count of pending spawn requests and releases one spawn every `interval` frames. Each spawn goes to the lowest-index slot that is neither alive nor just deployed. When all slots are busy, it stalls and retries on every following frame.

---
 rtl/spawn_pkg.sv | 15 +
 rtl/object_spawn_scheduler_if.sv | 29 ++
 rtl/lowest_free_slot.sv | 11 +
 rtl/object_spawn_scheduler.sv | 74 +++++++
 tb/tb_object_spawn_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spawn_pkg.sv
// spawn_pkg: shared scheduler state type and saturating pending-count arithmetic.
package spawn_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, STALL} spawn_state_t;

   function automatic logic [31:0] sat_add(input logic [31:0] cur, input logic [31:0] add,
                                           input logic dec, input logic [31:0] max,
                                           output logic sat);
      logic [31:0] s;
      s = cur + add - {31'd0, dec};
      sat = s > max;
      return sat ? max : s;
   endfunction

endpackage

// File: rtl/object_spawn_scheduler_if.sv
// object_spawn_scheduler_if: level/game-logic side and object-pool side of the spawn scheduler.
interface object_spawn_scheduler_if #(
   parameter int NUM_SLOTS  = 16,
   parameter int PEND_W     = 6,
   parameter int INTERVAL_W = 10
);
   logic                  startOfFrame;
   logic                  enable;
   logic                  add_valid;
   logic [3:0]            add_count;
   logic [INTERVAL_W-1:0] interval;
   logic                  flush;
   logic [NUM_SLOTS-1:0]  slot_alive;
   logic [NUM_SLOTS-1:0]  deploy;
   logic [PEND_W-1:0]     pending;
   logic                  busy;
   logic                  stalled;
   logic                  overflow;

   modport master (
      output startOfFrame, enable, add_valid, add_count, interval, flush, slot_alive,
      input  deploy, pending, busy, stalled, overflow
   );

   modport slave (
      input  startOfFrame, enable, add_valid, add_count, interval, flush, slot_alive,
      output deploy, pending, busy, stalled, overflow
   );
endinterface

// File: rtl/lowest_free_slot.sv
// lowest_free_slot: one-hot pick of the lowest set bit of the free mask.
module lowest_free_slot #(
   parameter int N = 16
) (
   input  logic [N-1:0] free,
   output logic [N-1:0] pick,
   output logic         found
);
   assign pick  = free & (~free + N'(1));
   assign found = |free;
endmodule

// File: rtl/object_spawn_scheduler.sv
// object_spawn_scheduler: frame-paced release of pending spawns into the lowest free object slot.
module object_spawn_scheduler
   import spawn_pkg::*;
#(
   parameter int NUM_SLOTS  = 16,
   parameter int PEND_W     = 6,
   parameter int INTERVAL_W = 10
) (
   input logic                  clk,
   input logic                  resetN,
   object_spawn_scheduler_if.slave bus
);
   localparam logic [31:0] PMAX = (32'd1 << PEND_W) - 32'd1;

   spawn_state_t          state, state_nxt;
   logic [INTERVAL_W-1:0] cnt, cnt_nxt, reload;
   logic [NUM_SLOTS-1:0]  reserved, pick, dep_nxt, deploy_r;
   logic [PEND_W-1:0]     pend_r, pend_sat, pend_nxt;
   logic                  ovf_r, ovf_nxt, sat, found, tick, dec, fire;

   assign reload  = bus.interval == '0 ? INTERVAL_W'(1) : bus.interval;
   // flush suppresses the whole frame decision, including the reserved-mask rewrite
   assign tick    = bus.startOfFrame && bus.enable && !bus.flush;
   assign dec     = state == WAIT && cnt > INTERVAL_W'(1);
   assign fire    = tick && state != IDLE && !dec && found;
   assign dep_nxt = fire ? pick : '0;

   lowest_free_slot #(.N(NUM_SLOTS)) u_pick (
      .free  (~bus.slot_alive & ~reserved),
      .pick  (pick),
      .found (found)
   );

   always_comb begin
      pend_sat  = PEND_W'(sat_add(32'(pend_r), 32'(bus.add_valid ? bus.add_count : 4'd0),
                                  fire, PMAX, sat));
      pend_nxt  = bus.flush ? '0 : pend_sat;
      ovf_nxt   = !bus.flush && (ovf_r || (bus.add_valid && sat));
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.flush) state_nxt = IDLE;
      else if (state == IDLE && pend_nxt != '0) begin
         state_nxt = WAIT;
         cnt_nxt   = reload;
      end else if (tick && state != IDLE) begin
         state_nxt = fire ? (pend_nxt == '0 ? IDLE : WAIT) : dec ? WAIT : STALL;
         cnt_nxt   = fire ? reload : dec ? cnt - INTERVAL_W'(1) : cnt;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= IDLE;
         cnt      <= '0;
         reserved <= '0;
         deploy_r <= '0;
         pend_r   <= '0;
         ovf_r    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         reserved <= tick ? dep_nxt : reserved;
         deploy_r <= dep_nxt;
         pend_r   <= pend_nxt;
         ovf_r    <= ovf_nxt;
      end
   end

   assign bus.deploy   = deploy_r;
   assign bus.pending  = pend_r;
   assign bus.busy     = state != IDLE;
   assign bus.stalled  = state == STALL;
   assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_object_spawn_scheduler.sv
// tb_object_spawn_scheduler: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_object_spawn_scheduler;
   localparam int NS = 16;
   localparam int PW = 6;
   localparam int IW = 10;
   localparam int PMAX = (1 << PW) - 1;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   int   total = 0;
   int   bad = 0;

   object_spawn_scheduler_if #(.NUM_SLOTS(NS), .PEND_W(PW), .INTERVAL_W(IW)) bus ();

   object_spawn_scheduler #(.NUM_SLOTS(NS), .PEND_W(PW), .INTERVAL_W(IW)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // reference model: pending spawns, frames left until the next release, stall flag
   int          m_pend, m_wait;
   bit          m_ovf, m_act, m_stall;
   logic [NS-1:0] m_res, m_dep;

   task automatic model_reset();
      m_pend = 0; m_wait = 0; m_ovf = 0; m_act = 0; m_stall = 0; m_res = '0; m_dep = '0;
   endtask

   task automatic model_step();
      logic [NS-1:0] free, dep;
      bit was;
      int ivl;
      dep = '0;
      was = m_act;
      ivl = (bus.interval == 0) ? 1 : int'(bus.interval);
      if (bus.flush) begin
         m_pend = 0; m_ovf = 0; m_act = 0; m_stall = 0;
      end else begin
         if (bus.startOfFrame && bus.enable) begin
            if (was) begin
               if (!m_stall && m_wait > 1) m_wait--;
               else begin
                  free = ~bus.slot_alive & ~m_res;
                  for (int i = 0; i < NS; i++) if (free[i] && dep == '0) dep[i] = 1'b1;
                  m_stall = (dep == '0);
               end
            end
            m_res = dep;
         end
         m_pend = m_pend + (bus.add_valid ? int'(bus.add_count) : 0) - ((dep != '0) ? 1 : 0);
         if (m_pend > PMAX) begin m_pend = PMAX; m_ovf = 1; end
         if (dep != '0) begin
            m_wait = ivl;
            if (m_pend == 0) m_act = 0;
         end
         if (!was && m_pend > 0) begin m_act = 1; m_wait = ivl; end
      end
      m_dep = dep;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      bus.startOfFrame = 1'b0;
      bus.add_valid    = 1'b0;
      bus.flush        = 1'b0;
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick();
   endtask

   task automatic add(input int n);
      bus.add_valid = 1'b1;
      bus.add_count = 4'(n);
      tick();
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      bus.startOfFrame = 1'b0; bus.add_valid = 1'b0; bus.flush = 1'b0;
      bus.slot_alive = '0; bus.enable = 1'b1; bus.interval = IW'(1); bus.add_count = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.deploy !== '0) begin bad++; $display("FAIL reset_deploy got=%h want=0", bus.deploy); end
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL reset_pending got=%0d want=0", bus.pending); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled got=%b want=0", bus.stalled); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
   endtask

   task automatic test_basic();
      logic [NS-1:0] e;
      do_reset();
      bus.interval = IW'(3);
      add(2);
      total++; if (bus.pending !== PW'(2)) begin bad++; $display("FAIL basic_pend0 got=%0d want=2", bus.pending); end
      for (int f = 1; f <= 6; f++) begin
         e = (f == 3) ? NS'(1) : (f == 6) ? NS'(2) : '0;
         frame();
         total++; if (bus.deploy !== e) begin bad++; $display("FAIL basic_deploy f%0d got=%h want=%h", f, bus.deploy, e); end
         if (f == 3) begin
            total++; if (bus.pending !== PW'(1)) begin bad++; $display("FAIL basic_pend3 got=%0d want=1", bus.pending); end
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy3 got=%b want=1", bus.busy); end
         end
         bus.slot_alive = bus.slot_alive | bus.deploy;
         tick();
      end
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL basic_pend6 got=%0d want=0", bus.pending); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy6 got=%b want=0", bus.busy); end
   endtask

   task automatic test_exhaust();
      logic [NS-1:0] e;
      do_reset();
      bus.slot_alive = '1;
      add(1);
      for (int f = 1; f <= 5; f++) begin
         e = (f == 5) ? NS'(16'h0020) : '0;
         frame();
         total++; if (bus.deploy !== e) begin bad++; $display("FAIL exhaust_deploy f%0d got=%h want=%h", f, bus.deploy, e); end
         total++; if (bus.stalled !== (f < 5)) begin bad++; $display("FAIL exhaust_stalled f%0d got=%b want=%b", f, bus.stalled, f < 5); end
         if (f == 4) bus.slot_alive[5] = 1'b0;
         tick();
      end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL exhaust_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_reservation();
      logic [NS-1:0] e;
      do_reset();
      add(3);
      for (int f = 1; f <= 3; f++) begin
         e = (f == 2) ? NS'(2) : NS'(1);
         frame();
         total++; if (bus.deploy !== e) begin bad++; $display("FAIL reserve_deploy f%0d got=%h want=%h", f, bus.deploy, e); end
         tick();
      end
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL reserve_pend got=%0d want=0", bus.pending); end
   endtask

   task automatic test_saturation();
      int e;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         add(15);
         e = (15 * k > PMAX) ? PMAX : 15 * k;
         total++; if (bus.pending !== PW'(e)) begin bad++; $display("FAIL sat_pend k%0d got=%0d want=%0d", k, bus.pending, e); end
         total++; if (bus.overflow !== (k == 5)) begin bad++; $display("FAIL sat_ovf k%0d got=%b want=%b", k, bus.overflow, k == 5); end
      end
      bus.flush = 1'b1;
      bus.startOfFrame = 1'b1;
      tick();
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL flush_pend got=%0d want=0", bus.pending); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b want=0", bus.overflow); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
      total++; if (bus.deploy !== '0) begin bad++; $display("FAIL flush_deploy got=%h want=0", bus.deploy); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      add(1);
      bus.startOfFrame = 1'b1;
      add(4);
      total++; if (bus.deploy !== NS'(1)) begin bad++; $display("FAIL simul_deploy got=%h want=1", bus.deploy); end
      total++; if (bus.pending !== PW'(4)) begin bad++; $display("FAIL simul_pend got=%0d want=4", bus.pending); end
   endtask

   task automatic test_pause_reset();
      do_reset();
      bus.interval = IW'(5);
      add(2);
      repeat (3) begin frame(); tick(); end
      bus.enable = 1'b0;
      for (int f = 0; f < 10; f++) begin
         frame();
         total++; if (bus.deploy !== '0) begin bad++; $display("FAIL pause_deploy f%0d got=%h want=0", f, bus.deploy); end
         tick();
      end
      bus.enable = 1'b1;
      frame();
      total++; if (bus.deploy !== '0) begin bad++; $display("FAIL resume1_deploy got=%h want=0", bus.deploy); end
      tick();
      frame();
      total++; if (bus.deploy !== NS'(1)) begin bad++; $display("FAIL resume2_deploy got=%h want=1", bus.deploy); end
      resetN = 1'b0;
      #1;
      total++; if (bus.deploy !== '0) begin bad++; $display("FAIL rst_deploy got=%h want=0", bus.deploy); end
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL rst_pend got=%0d want=0", bus.pending); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
      model_reset();
      @(posedge clk);
      #1 resetN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (bus.deploy !== '0) begin bad++; $display("FAIL rst_exit_deploy c%0d got=%h want=0", c, bus.deploy); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.startOfFrame = ($urandom_range(0, 3) == 0);
         bus.enable       = ($urandom_range(0, 9) != 0);
         bus.add_valid    = ($urandom_range(0, 39) == 0);
         bus.add_count    = 4'($urandom_range(0, 15));
         bus.flush        = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 49) == 0) bus.interval = IW'($urandom_range(0, 4));
         bus.slot_alive = bus.slot_alive | bus.deploy;
         if ($urandom_range(0, 2) == 0) bus.slot_alive[$urandom_range(0, NS - 1)] = 1'b0;
         if ($urandom_range(0, 299) == 0) bus.slot_alive = '1;
         tick();
         total++; if (bus.deploy !== m_dep) begin bad++; $display("FAIL rnd_deploy c%0d got=%h want=%h", c, bus.deploy, m_dep); end
         total++; if (bus.pending !== PW'(m_pend)) begin bad++; $display("FAIL rnd_pend c%0d got=%0d want=%0d", c, bus.pending, m_pend); end
         total++; if (bus.busy !== m_act) begin bad++; $display("FAIL rnd_busy c%0d got=%b want=%b", c, bus.busy, m_act); end
         total++; if (bus.stalled !== m_stall) begin bad++; $display("FAIL rnd_stalled c%0d got=%b want=%b", c, bus.stalled, m_stall); end
         total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c%0d got=%b want=%b", c, bus.overflow, m_ovf); end
      end
   endtask

   initial begin
      bus.startOfFrame = 1'b0; bus.enable = 1'b0; bus.add_valid = 1'b0; bus.add_count = '0;
      bus.interval = IW'(1); bus.flush = 1'b0; bus.slot_alive = '0;
      test_reset();
      test_basic();
      test_exhaust();
      test_reservation();
      test_saturation();
      test_simultaneous();
      test_pause_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
